mem_port_arbiter: RTL and testbench

//  Shares one single-port, fixed-latency unified memory between instruction fetch (IF) and the
//  MEM-stage data access (D) of the pipelined RISC-V core. Holds a 2-state FSM and a latency

---
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port, fixed-latency memory between
// instruction fetch (IF) and data access (D). Data has priority, but fetch
// is forced through after MAX_D_RUN consecutive data grants while it waits.
// The cycle in which a completion pulse is out is a turnaround cycle: no new
// grant is made, so every access occupies MEM_LAT+3 cycles from grant to the
// next possible grant.
module mem_port_arbiter #(
  parameter int DW        = 32,
  parameter int MEM_LAT   = 2,
  parameter int MAX_D_RUN = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req_i,
  input  logic [DW-1:0] if_addr_i,
  output logic          if_valid_o,
  output logic [DW-1:0] if_rdata_o,
  output logic          if_stall_o,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [DW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  input  logic [3:0]    d_be_i,
  output logic          d_valid_o,
  output logic [DW-1:0] d_rdata_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [DW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic [3:0]    mem_be_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          busy_o
);

  localparam int CW = $clog2(MEM_LAT + 1);
  localparam int RW = $clog2(MAX_D_RUN + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_reg, state_next;
  logic            owner_reg;          // 0 = fetch, 1 = data
  logic [CW-1:0]   cnt_reg;
  logic [RW-1:0]   d_run_reg;
  logic [DW-1:0]   mem_addr_reg, mem_wdata_reg;
  logic [3:0]      mem_be_reg;
  logic            mem_we_reg;
  logic [DW-1:0]   if_rdata_reg, d_rdata_reg;
  logic            if_valid_reg, d_valid_reg;

  logic            arb_ok, grant_d, grant_if, done;

  // Arbitration and completion decode
  always_comb begin
    arb_ok   = (state_reg == IDLE) && !if_valid_reg && !d_valid_reg;
    grant_d  = arb_ok && d_req_i && !(if_req_i && (d_run_reg == RW'(MAX_D_RUN)));
    grant_if = arb_ok && if_req_i && !grant_d;
    done     = (state_reg == BUSY) && (cnt_reg == CW'(MEM_LAT));
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // FSM next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_d || grant_if) state_next = BUSY;
      BUSY:    if (done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Command latch, latency counter, run limiter and read-data capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_reg     <= 1'b0;
      cnt_reg       <= '0;
      d_run_reg     <= '0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_be_reg    <= '0;
      mem_we_reg    <= 1'b0;
      if_rdata_reg  <= '0;
      d_rdata_reg   <= '0;
      if_valid_reg  <= 1'b0;
      d_valid_reg   <= 1'b0;
    end else begin
      if_valid_reg <= done && !owner_reg;
      d_valid_reg  <= done && owner_reg;
      if (grant_d) begin
        owner_reg     <= 1'b1;
        cnt_reg       <= '0;
        mem_addr_reg  <= d_addr_i;
        mem_wdata_reg <= d_wdata_i;
        mem_be_reg    <= d_be_i;
        mem_we_reg    <= d_we_i;
        if (!if_req_i)                            d_run_reg <= '0;
        else if (d_run_reg != RW'(MAX_D_RUN))     d_run_reg <= d_run_reg + 1'b1;
      end else if (grant_if) begin
        owner_reg     <= 1'b0;
        cnt_reg       <= '0;
        mem_addr_reg  <= if_addr_i;
        mem_wdata_reg <= '0;
        mem_be_reg    <= 4'b1111;
        mem_we_reg    <= 1'b0;
        d_run_reg     <= '0;
      end else if (state_reg == BUSY && !done) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      if (done) begin
        cnt_reg <= '0;
        if (owner_reg) d_rdata_reg  <= mem_we_reg ? '0 : mem_rdata_i;
        else           if_rdata_reg <= mem_rdata_i;
      end
    end
  end

  // Output decode: strobes only qualify the single command cycle
  always_comb begin
    busy_o      = (state_reg == BUSY);
    mem_en_o    = busy_o && (cnt_reg == '0);
    mem_we_o    = mem_en_o && mem_we_reg;
    mem_be_o    = mem_en_o ? mem_be_reg : 4'b0000;
    mem_wdata_o = mem_en_o ? mem_wdata_reg : '0;
    mem_addr_o  = mem_addr_reg;
    if_valid_o  = if_valid_reg;
    d_valid_o   = d_valid_reg;
    if_rdata_o  = if_rdata_reg;
    d_rdata_o   = d_rdata_reg;
    if_stall_o  = if_req_i && !if_valid_reg;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with MEM_LAT=2, one with
// MEM_LAT=1. A scoreboard queue per port holds expected data and the cycle of
// the completion pulse; a negedge monitor pops and compares.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // MEM_LAT=2 instance signals
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [3:0]  d_be;
  logic        if_valid, if_stall, d_valid, mem_en, mem_we, busy;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  // MEM_LAT=1 instance signals
  logic        if1_req;
  logic [31:0] if1_addr;
  logic        d1_req, d1_we;
  logic [31:0] d1_addr, d1_wdata;
  logic [3:0]  d1_be;
  logic        if1_valid, if1_stall, d1_valid, mem1_en, mem1_we, busy1;
  logic [31:0] if1_rdata, d1_rdata, mem1_addr, mem1_wdata, mem1_rdata;
  logic [3:0]  mem1_be;

  mem_port_arbiter #(.DW(32), .MEM_LAT(2), .MAX_D_RUN(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_valid_o(if_valid),
    .if_rdata_o(if_rdata), .if_stall_o(if_stall),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_be_i(d_be), .d_valid_o(d_valid), .d_rdata_o(d_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_rdata_i(mem_rdata),
    .busy_o(busy)
  );

  mem_port_arbiter #(.DW(32), .MEM_LAT(1), .MAX_D_RUN(4)) dut1 (
    .clk(clk), .rst(rst),
    .if_req_i(if1_req), .if_addr_i(if1_addr), .if_valid_o(if1_valid),
    .if_rdata_o(if1_rdata), .if_stall_o(if1_stall),
    .d_req_i(d1_req), .d_we_i(d1_we), .d_addr_i(d1_addr), .d_wdata_i(d1_wdata),
    .d_be_i(d1_be), .d_valid_o(d1_valid), .d_rdata_o(d1_rdata),
    .mem_en_o(mem1_en), .mem_we_o(mem1_we), .mem_addr_o(mem1_addr),
    .mem_wdata_o(mem1_wdata), .mem_be_o(mem1_be), .mem_rdata_i(mem1_rdata),
    .busy_o(busy1)
  );

  // Memory model: data is only valid exactly MEM_LAT cycles after the strobe
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h10) return 32'h00A00093;
    return {a[15:0], ~a[15:0]};
  endfunction

  logic [1:0] en_sh;
  logic       en1_sh;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      en_sh  <= 2'b00;
      en1_sh <= 1'b0;
    end else begin
      en_sh  <= {en_sh[0], mem_en};
      en1_sh <= mem1_en;
    end
  end
  assign mem_rdata  = en_sh[1] ? mem_fn(mem_addr)  : 32'hBAD0BAD0;
  assign mem1_rdata = en1_sh   ? mem_fn(mem1_addr) : 32'hBAD0BAD0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t if_q[$];
  exp_t d_q[$];

  // Scoreboard monitor for the MEM_LAT=2 instance
  always @(negedge clk) begin
    exp_t e;
    if (if_valid) begin
      if (if_q.size() == 0) chk("if_unexpected_valid", 32'd1, 32'd0);
      else begin
        e = if_q.pop_front();
        chk("if_rdata", if_rdata, e.data);
        chk("if_valid_cycle", 32'(cyc), 32'(e.cyc));
        $display("IF  completion cycle %0d data %h", cyc, if_rdata);
      end
    end
    if (d_valid) begin
      if (d_q.size() == 0) chk("d_unexpected_valid", 32'd1, 32'd0);
      else begin
        e = d_q.pop_front();
        chk("d_rdata", d_rdata, e.data);
        chk("d_valid_cycle", 32'(cyc), 32'(e.cyc));
        $display("D   completion cycle %0d data %h", cyc, d_rdata);
      end
    end
  end

  initial begin
    int t;
    rst = 1'b0;
    if_req = 0; d_req = 0; d_we = 0; if_addr = 0; d_addr = 0; d_wdata = 0; d_be = 0;
    if1_req = 0; if1_addr = 0; d1_req = 0; d1_we = 0; d1_addr = 0; d1_wdata = 0; d1_be = 0;
    #1 rst = 1'b1;

    // Reset state
    wait_cyc(2);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_valid", 32'(d_valid), 32'd0);
    wait_cyc(3);
    rst = 1'b0;

    // Single fetch
    t = 5;
    wait_cyc(t);
    if_addr = 32'h10; if_req = 1;
    if_q.push_back('{32'h00A00093, t + 4});
    #1 chk("fetch_stall_wait", 32'(if_stall), 32'd1);
    wait_cyc(t + 1);
    chk("fetch_mem_en", 32'(mem_en), 32'd1);
    chk("fetch_mem_addr", mem_addr, 32'h10);
    chk("fetch_mem_be", 32'(mem_be), 32'hF);
    chk("fetch_mem_we", 32'(mem_we), 32'd0);
    wait_cyc(t + 2);
    chk("fetch_mem_en_once", 32'(mem_en), 32'd0);
    wait_cyc(t + 4);
    chk("fetch_stall_done", 32'(if_stall), 32'd0);
    if_req = 0;

    // Reset in the cycle after the strobe aborts the access
    t = 12;
    wait_cyc(t);
    if_addr = 32'h20; if_req = 1;
    wait_cyc(t + 2);
    chk("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1; if_req = 0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_mem_addr", mem_addr, 32'd0);
    chk("abort_mem_en", 32'(mem_en), 32'd0);
    chk("abort_if_rdata", if_rdata, 32'd0);
    chk("abort_if_valid", 32'(if_valid), 32'd0);
    wait_cyc(t + 3);
    rst = 1'b0;

    // Data write
    t = 20;
    wait_cyc(t);
    d_addr = 32'h104; d_wdata = 32'hDEADBEEF; d_be = 4'b0011; d_we = 1; d_req = 1;
    d_q.push_back('{32'h0, t + 4});
    wait_cyc(t + 1);
    chk("wr_mem_en", 32'(mem_en), 32'd1);
    chk("wr_mem_we", 32'(mem_we), 32'd1);
    chk("wr_mem_be", 32'(mem_be), 32'h3);
    chk("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("wr_mem_addr", mem_addr, 32'h104);
    wait_cyc(t + 2);
    chk("wr_mem_we_off", 32'(mem_we), 32'd0);
    chk("wr_mem_be_off", 32'(mem_be), 32'd0);
    chk("wr_mem_wdata_off", mem_wdata, 32'd0);
    wait_cyc(t + 4);
    d_req = 0; d_we = 0;

    // Simultaneous requests: data first, fetch after the turnaround cycle
    t = 30;
    wait_cyc(t);
    if_addr = 32'h40; d_addr = 32'h80; d_be = 4'b1100; if_req = 1; d_req = 1;
    d_q.push_back('{mem_fn(32'h80), t + 4});
    if_q.push_back('{mem_fn(32'h40), t + 9});
    wait_cyc(t + 1);
    chk("both_first_addr", mem_addr, 32'h80);
    chk("both_first_be", 32'(mem_be), 32'hC);
    wait_cyc(t + 4);
    d_req = 0;
    wait_cyc(t + 5);
    chk("both_gap_en", 32'(mem_en), 32'd0);
    wait_cyc(t + 6);
    chk("both_if_en", 32'(mem_en), 32'd1);
    chk("both_if_addr", mem_addr, 32'h40);
    chk("both_if_be", 32'(mem_be), 32'hF);
    wait_cyc(t + 9);
    if_req = 0;

    // Starvation limit: 4 data grants, 1 fetch grant, then data resumes
    t = 45;
    wait_cyc(t);
    if_addr = 32'h200; d_addr = 32'h300; d_be = 4'hF; if_req = 1; d_req = 1;
    for (int k = 0; k < 6; k++) begin
      if (k == 4) if_q.push_back('{mem_fn(32'h200), t + 5 * k + 4});
      else        d_q.push_back('{mem_fn(32'h300), t + 5 * k + 4});
    end
    for (int k = 0; k < 6; k++) begin
      wait_cyc(t + 5 * k + 1);
      chk("run_grant_addr", mem_addr, (k == 4) ? 32'h200 : 32'h300);
      chk("run_grant_en", 32'(mem_en), 32'd1);
    end
    wait_cyc(t + 29);
    if_req = 0; d_req = 0;

    // MEM_LAT=1: held fetch request gives one access every 4 cycles
    t = 80;
    wait_cyc(t);
    if1_addr = 32'h44; if1_req = 1;
    for (int c = t; c <= t + 11; c++) begin
      wait_cyc(c);
      chk("lat1_mem_en", 32'(mem1_en), 32'(((c - t) % 4) == 1));
      chk("lat1_if_valid", 32'(if1_valid), 32'(((c - t) % 4) == 3));
      if (((c - t) % 4) == 3) begin
        chk("lat1_if_rdata", if1_rdata, mem_fn(32'h44));
        $display("IF1 completion cycle %0d data %h", cyc, if1_rdata);
      end
    end
    if1_req = 0;

    wait_cyc(t + 16);
    chk("if_q_drained", 32'(if_q.size()), 32'd0);
    chk("d_q_drained", 32'(d_q.size()), 32'd0);
    chk("final_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
